mem_miss_arbiter: RTL

Parametrised multi-channel miss handler between the pipeline's caches and the shared multi-cycle, pipelined main memory. It accepts block-fill (read) and single-word write-through requests from `NUM_CH` channels, grants one at a time round-robin, streams block reads to memory one word per cycle, and returns words to the owning cache with per-word write strobes. It is the generalised successor of the fixed I/D `cache_stall` path and sits between the cache arrays and `memory4c`.

---
 rtl/mem_miss_arbiter_if.sv | 44 ++++
 rtl/mem_miss_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_miss_arbiter_if.sv
// Cache-side request/fill bus and memory command bus
// of the multi-channel miss arbiter.
interface mem_miss_arbiter_if #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int OFF_W = $clog2(BLOCK_WORDS);

  logic [NUM_CH-1:0]        req;
  logic [NUM_CH-1:0]        req_wr;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [NUM_CH-1:0]        gnt;
  logic [NUM_CH-1:0]        done;
  logic                     fill_we;
  logic [CH_W-1:0]          fill_ch;
  logic [OFF_W-1:0]         fill_idx;
  logic [DATA_W-1:0]        fill_data;
  logic                     mem_en;
  logic                     mem_wr;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     mem_rvalid;

  modport slave (
    input  req, req_wr, req_addr, req_wdata,
    input  mem_rdata, mem_rvalid,
    output gnt, done,
    output fill_we, fill_ch, fill_idx, fill_data,
    output mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req, req_wr, req_addr, req_wdata,
    output mem_rdata, mem_rvalid,
    input  gnt, done,
    input  fill_we, fill_ch, fill_idx, fill_data,
    input  mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_miss_arbiter.sv
// Round-robin miss handler: block fills and
// write-through words to a pipelined memory.
module mem_miss_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8
) (
  input logic               clk,
  input logic               rst_n,
  mem_miss_arbiter_if.slave bus
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam logic [OFF_W-1:0] LAST_IDX = OFF_W'(BLOCK_WORDS-1);
  localparam logic [OFF_W-1:0] ONE      = OFF_W'(1);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, WRITE, DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     last_q, last_d;
  logic [CH_W-1:0]     owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [OFF_W-1:0]    iss_q, iss_d;
  logic [OFF_W-1:0]    ret_q, ret_d;
  logic [NUM_CH-1:0]   gnt_q, gnt_d;
  logic [NUM_CH-1:0]   done_q, done_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                found;
  logic [CH_W-1:0]     pick;
  int                  cand;
  logic [ADDR_W-1:0]   pick_addr;
  logic [DATA_W-1:0]   pick_wdata;
  logic [ADDR_W-1:0]   pick_base;
  logic [ADDR_W-1:0]   base;
  logic                fill_act;

  assign pick_addr  = bus.req_addr[int'(pick)*ADDR_W +: ADDR_W];
  assign pick_wdata = bus.req_wdata[int'(pick)*DATA_W +: DATA_W];
  assign pick_base  = {pick_addr[ADDR_W-1:OFF_W+1], {(OFF_W+1){1'b0}}};
  assign base       = {addr_q[ADDR_W-1:OFF_W+1], {(OFF_W+1){1'b0}}};
  assign fill_act   = bus.mem_rvalid &&
                      (state_q == RD_ISSUE || state_q == RD_WAIT);

  // Cyclic search for the first requester after the last owner
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = (int'(last_q) + k) % NUM_CH;
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = CH_W'(cand);
      end
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    iss_d       = iss_q;
    ret_d       = ret_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    mem_en_d    = mem_en_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          owner_d      = pick;
          last_d       = pick;
          gnt_d        = '0;
          gnt_d[pick]  = 1'b1;
          addr_d       = pick_addr;
          iss_d        = '0;
          ret_d        = '0;
          mem_en_d     = 1'b1;
          if (bus.req_wr[pick]) begin
            state_d     = WRITE;
            mem_wr_d    = 1'b1;
            mem_addr_d  = {pick_addr[ADDR_W-1:1], 1'b0};
            mem_wdata_d = pick_wdata;
          end else begin
            state_d     = RD_ISSUE;
            mem_wr_d    = 1'b0;
            mem_addr_d  = pick_base;
          end
        end
      end
      RD_ISSUE, RD_WAIT: begin
        if (state_q == RD_ISSUE) begin
          if (iss_q == LAST_IDX) begin
            state_d    = RD_WAIT;
            mem_en_d   = 1'b0;
            mem_addr_d = '0;
          end else begin
            iss_d      = iss_q + ONE;
            mem_addr_d = base + ADDR_W'({iss_q + ONE, 1'b0});
          end
        end
        if (fill_act) begin
          ret_d = ret_q + ONE;
          if (ret_q == LAST_IDX) begin
            state_d         = DONE;
            done_d[owner_q] = 1'b1;
            mem_en_d        = 1'b0;
            mem_addr_d      = '0;
          end
        end
      end
      WRITE: begin
        state_d         = DONE;
        done_d[owner_q] = 1'b1;
        mem_en_d        = 1'b0;
        mem_wr_d        = 1'b0;
        mem_addr_d      = '0;
        mem_wdata_d     = '0;
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= CH_W'(NUM_CH-1);
      owner_q     <= '0;
      addr_q      <= '0;
      iss_q       <= '0;
      ret_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      iss_q       <= iss_d;
      ret_q       <= ret_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.fill_we   = fill_act;
  assign bus.fill_ch   = fill_act ? owner_q : '0;
  assign bus.fill_idx  = fill_act ? ret_q : '0;
  assign bus.fill_data = fill_act ? bus.mem_rdata : '0;
endmodule
